rom_image_loader: RTL and testbench
===================================

Name: rom_image_loader

Overview:
- Writer-side companion to the instruction-ROM address select mux.
- Accepts a program image as a valid/ready word stream and writes it into instruction memory at sequential addresses.
- Drives the mux select line so the memory sees the loader address while loading and the CPU PC otherwise.
- Holds the CPU stalled for the whole load; the CPU runs from address 0 once the load completes.

Parameters:
- ADDR_W, 10, instruction memory address width; must match the select mux width.
- DATA_W, 32, instruction word width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE and DONE.
- load_len  in  ADDR_W+1  number of words to load, sampled with start; legal range 0..2^ADDR_W.
- in_valid  in  1  stream word available.
- in_data  in  DATA_W  stream word.
- in_ready  out  1  loader accepts in_data this cycle.
- mem_addr  out  ADDR_W  loader write address; feeds the mux input selected when sel=1.
- mem_wdata  out  DATA_W  write data.
- mem_we  out  1  memory write enable.
- sel  out  1  mux select: 1 = loader address, 0 = CPU PC.
- cpu_hold  out  1  stalls the CPU PC/commit while high.
- busy  out  1  a load is in progress.
- done  out  1  sticky load-complete flag.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, count=0, len_q=0.
  - sel=0, mem_we=0, in_ready=0, cpu_hold=0, busy=0, done=0, mem_addr=0.
  - Reset mid-load aborts the load with no further writes; memory contents are then undefined.
- States: IDLE, LOAD, FLUSH, DONE.
- IDLE or DONE with start=1:
  - Capture len_q=load_len, count=0, clear done.
  - If load_len==0, go to DONE; done=1 the next cycle and no write occurs.
  - Otherwise go to LOAD.
- LOAD:
  - sel=1, cpu_hold=1, busy=1, in_ready=1.
  - mem_addr=count[ADDR_W-1:0], driven from a register.
  - mem_we=in_valid&in_ready and mem_wdata=in_data, both combinational. The write lands the same cycle as the handshake (zero-latency pass-through).
  - On each handshake, count increments.
  - When the handshake occurs with count==len_q-1, go to FLUSH.
  - in_valid low: wait indefinitely; no timeout.
- FLUSH, one cycle:
  - in_ready=0, mem_we=0.
  - sel=1 and cpu_hold=1 held, so the final write settles before the address source switches.
  - Next state DONE.
- DONE:
  - sel=0, cpu_hold=0, busy=0, in_ready=0, done=1.
  - done remains high until the next accepted start or reset.
- start while in LOAD or FLUSH is ignored; len_q is not re-sampled.
- load_len>2^ADDR_W: clamp len_q to 2^ADDR_W.
- Full-memory load (len=2^ADDR_W): count is ADDR_W+1 bits wide. The last write is to address 2^ADDR_W-1, and mem_addr never wraps to 0 within a load.
- in_data is ignored whenever in_ready=0; in_valid may be held high across FLUSH and DONE without effect.
- Outputs sel, cpu_hold, busy, done and in_ready are registered, decoded from the state register. Only mem_we and mem_wdata are combinational.

Test Plan:
- Reset, then start with load_len=4 and in_valid held high, data 0xA0..0xA3:
  - mem_we high for exactly 4 consecutive cycles at addresses 0,1,2,3.
  - One FLUSH cycle with sel=1, then sel=0, cpu_hold=0, done=1.
- load_len=3 with in_valid toggling 1,0,0,1,0,1:
  - Exactly 3 writes, addresses 0,1,2, in handshake order.
  - No write on the in_valid=0 cycles.
  - in_ready stays high until the 3rd handshake.
- load_len=0 → no mem_we, sel stays 0, done=1 one cycle after start.
- load_len=1024 with continuous valid:
  - The last write is to address 1023 with no write to address 0 after it.
  - done asserts 2 cycles after the final handshake.
- start pulsed mid-load with load_len=2 during an 8-word load → 8 writes total, len unchanged.
- Second start after DONE: done clears the next cycle and the count restarts at address 0.
- rst_n low during the 3rd word of a 6-word load:
  - sel, mem_we and in_ready drop to 0 asynchronously, before the next clk edge.
  - After release, state is IDLE and done=0.

Source files
------------

// File: rtl/rom_image_loader.sv
// rom_image_loader
// Streams a program image into instruction memory and owns the
// instruction-ROM address select mux while the load is running.
// The CPU is held in stall for the whole load and is released into
// a memory image that starts at address 0.
//
// Ports
//   clk, rst_n  rising-edge clock; asynchronous active-low reset
//   start       one-cycle load request, sampled only in IDLE / DONE
//   load_len    number of words to load, sampled with start
//               (values above 2^ADDR_W are clamped to 2^ADDR_W)
//   in_valid    stream word available
//   in_data     stream word
//   in_ready    loader accepts in_data this cycle
//   mem_addr    write address, routed through the mux when sel=1
//   mem_wdata   write data (pass-through of in_data)
//   mem_we      write enable, high on each stream handshake
//   sel         mux select: 1 = loader address, 0 = CPU PC
//   cpu_hold    stalls CPU PC/commit
//   busy        load in progress
//   done        sticky load-complete flag
module rom_image_loader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              sel,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    state_t            state, state_nx;
    logic [ADDR_W:0]   count, count_nx;
    logic [ADDR_W:0]   len_q, len_nx;
    logic [ADDR_W-1:0] addr_q, addr_nx;
    logic              hs;
    logic              last;

    // Status outputs are pure decodes of the state register, so they
    // fall immediately when reset is asserted.
    assign in_ready = (state == LOAD);
    assign sel      = (state == LOAD) || (state == FLUSH);
    assign cpu_hold = (state == LOAD) || (state == FLUSH);
    assign busy     = (state == LOAD) || (state == FLUSH);
    assign done     = (state == DONE);

    assign hs        = in_valid & in_ready;
    assign mem_we    = hs;
    assign mem_wdata = in_data;
    assign mem_addr  = addr_q;
    assign last      = (count == len_q - ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            len_q  <= '0;
            addr_q <= '0;
        end else begin
            state  <= state_nx;
            count  <= count_nx;
            len_q  <= len_nx;
            addr_q <= addr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        count_nx = count;
        len_nx   = len_q;
        addr_nx  = addr_q;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    len_nx   = (load_len > FULL) ? FULL : load_len;
                    count_nx = '0;
                    addr_nx  = '0;
                    state_nx = (load_len == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (hs) begin
                    count_nx = count + ONE;
                    // The address register freezes on the final word so a
                    // full-memory load never presents address 0 again while
                    // the mux still selects the loader during FLUSH.
                    if (last) state_nx = FLUSH;
                    else      addr_nx  = count_nx[ADDR_W-1:0];
                end
            end
            FLUSH:   state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rom_image_loader.sv
module tb_rom_image_loader;

    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int MEM = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW:0]   load_len;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          sel;
    logic          cpu_hold;
    logic          busy;
    logic          done;

    int vec  = 0;
    int miss = 0;

    // writes seen on the memory port, and writes the reference model expects
    int            got_a[$];
    logic [DW-1:0] got_d[$];
    int            exp_a[$];
    logic [DW-1:0] exp_d[$];

    rom_image_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .load_len(load_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .sel(sel), .cpu_hold(cpu_hold), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_we === 1'b1) begin
            got_a.push_back(int'(mem_addr));
            got_d.push_back(mem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        got_a.delete(); got_d.delete(); exp_a.delete(); exp_d.delete();
    endtask

    // One complete load. vprob<0 selects the fixed valid pattern 1,0,0,1,0,1;
    // dbase!=0 gives data dbase+i instead of random; mid_start>=0 pulses a
    // stray start (len 2) on that cycle of the load.
    task automatic run_load(input int len, input int vprob, input int dbase, input int mid_start);
        int n, hs, cyc, bound;
        logic v;
        logic [DW-1:0] d;
        logic [5:0] pat;
        pat = 6'b101001;
        n = (len > MEM) ? MEM : len;
        clear_q();
        @(posedge clk); #1;
        start = 1'b1; load_len = len[AW:0]; in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        if (n == 0) begin
            in_valid = 1'b1;
            @(negedge clk);
            chk("zero_done", 64'(done), 64'd1);
            chk("zero_sel", 64'(sel), 64'd0);
            chk("zero_we", 64'(mem_we), 64'd0);
            chk("zero_busy", 64'(busy), 64'd0);
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("zero_nwrites", 64'(got_a.size()), 64'd0);
            return;
        end
        hs = 0; cyc = 0; bound = n * 20 + 50;
        while (hs < n && cyc < bound) begin
            if (vprob < 0) v = pat[cyc % 6];
            else           v = ($urandom_range(99) < vprob);
            d = (dbase != 0) ? DW'(dbase + hs) : DW'($urandom);
            in_valid = v; in_data = d;
            if (cyc == mid_start) begin start = 1'b1; load_len = 11'd2; end
            @(negedge clk);
            chk("load_ready", 64'(in_ready), 64'd1);
            chk("load_sel", 64'(sel), 64'd1);
            chk("load_hold", 64'(cpu_hold), 64'd1);
            chk("load_done", 64'(done), 64'd0);
            chk("load_we", 64'(mem_we), 64'(v));
            chk("load_addr", 64'(mem_addr), 64'(hs));
            if (v) begin
                exp_a.push_back(hs); exp_d.push_back(d); hs++;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        chk("handshakes", 64'(hs), 64'(n));
        in_valid = 1'($urandom_range(1));
        in_data  = $urandom;
        @(negedge clk);
        chk("flush_ready", 64'(in_ready), 64'd0);
        chk("flush_we", 64'(mem_we), 64'd0);
        chk("flush_sel", 64'(sel), 64'd1);
        chk("flush_hold", 64'(cpu_hold), 64'd1);
        chk("flush_done", 64'(done), 64'd0);
        if (n == MEM) chk("flush_nowrap", 64'(mem_addr == '0), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b1;
        @(negedge clk);
        chk("done_sel", 64'(sel), 64'd0);
        chk("done_hold", 64'(cpu_hold), 64'd0);
        chk("done_busy", 64'(busy), 64'd0);
        chk("done_ready", 64'(in_ready), 64'd0);
        chk("done_we", 64'(mem_we), 64'd0);
        chk("done_flag", 64'(done), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("nwrites", 64'(got_a.size()), 64'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            chk("wr_addr", 64'(got_a[i]), 64'(exp_a[i]));
            chk("wr_data", 64'(got_d[i]), 64'(exp_d[i]));
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; load_len = '0; in_valid = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel", 64'(sel), 64'd0);
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_hold", 64'(cpu_hold), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        rst_n = 1'b1;

        run_load(4, 100, 32'hA0, -1);       // basic, data A0..A3
        run_load(3, -1, 0, -1);             // valid 1,0,0,1,0,1
        run_load(0, 100, 0, -1);            // empty image
        run_load(MEM, 100, 0, -1);          // full memory
        run_load(8, 60, 0, 3);              // stray start mid-load
        run_load(5, 70, 0, -1);             // restart after DONE
        for (int k = 0; k < 4; k++)
            run_load(int'($urandom_range(40, 1)), int'($urandom_range(100, 30)), 0, -1);

        // reset in the middle of the 3rd word of a 6-word load
        clear_q();
        @(posedge clk); #1;
        start = 1'b1; load_len = 11'd6; in_valid = 1'b1; in_data = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; in_data = $urandom; end
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_sel", 64'(sel), 64'd0);
        chk("arst_we", 64'(mem_we), 64'd0);
        chk("arst_ready", 64'(in_ready), 64'd0);
        chk("arst_hold", 64'(cpu_hold), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_idle_done", 64'(done), 64'd0);
        chk("arst_idle_busy", 64'(busy), 64'd0);
        chk("arst_idle_we", 64'(mem_we), 64'd0);
        in_valid = 1'b0;

        run_load(1500, 100, 0, -1);         // oversize length clamps to full memory

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
